// File: rtl/song_seq_pkg.sv
// rtl/song_seq_pkg.sv - shared types and note-entry field constants for song_sequencer
package song_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_NOTE,
    S_GAP
  } state_t;

  // Entry layout is {dur, hp}; hp sits at the bottom, dur directly above it.
  localparam int HP_LSB  = 0;
  localparam int END_DUR = 0;
  localparam int REST_HP = 0;

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - enabled clock divider emitting one tick every TICK_DIV enabled cycles
module tick_divider #(
  parameter int TICK_DIV = 20910
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DIV_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == DIV_W'(TICK_DIV - 1));
  assign o_tick = i_en & ~i_clr & w_wrap;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - note-table walker driving the tone generator gate and half-period
// SONG_SEQUENCER_LOOP_EN: restart from entry 0 at end of song instead of returning to idle.
module song_sequencer
  import song_seq_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int HP_W      = 15,
  parameter int DUR_W     = 8,
  parameter int TICK_DIV  = 20910,
  parameter int GAP_TICKS = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_play,
  input  logic                    i_stop,
  output logic [ADDR_W-1:0]       o_rom_addr,
  input  logic [DUR_W+HP_W-1:0]   i_rom_data,
  output logic [HP_W-1:0]         o_half_period,
  output logic                    o_tone_en,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int DUR_LSB = HP_LSB + HP_W;
  localparam int GAP_W   = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  state_t             r_state, w_state_n;
  logic [ADDR_W-1:0]  r_addr, w_addr_n;
  logic [HP_W-1:0]    r_hp, w_hp_n;
  logic [DUR_W-1:0]   r_rem, w_rem_n;
  logic [GAP_W-1:0]   r_gap, w_gap_n;
  logic               r_tone, w_tone_n;
  logic               r_done, w_done_n;
  logic               w_div_clr, w_div_en, w_tick;
  logic               w_adv, w_end;
  logic [HP_W-1:0]    w_hp;
  logic [DUR_W-1:0]   w_dur;

  assign w_hp  = i_rom_data[HP_LSB +: HP_W];
  assign w_dur = i_rom_data[DUR_LSB +: DUR_W];

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_div_clr),
    .i_en   (w_div_en),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_n = r_state;
    w_addr_n  = r_addr;
    w_hp_n    = r_hp;
    w_rem_n   = r_rem;
    w_gap_n   = r_gap;
    w_tone_n  = r_tone;
    w_done_n  = 1'b0;
    w_div_clr = 1'b0;
    w_div_en  = 1'b0;
    w_adv     = 1'b0;
    w_end     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_addr_n = '0;
        w_tone_n = 1'b0;
        if (i_play) w_state_n = S_FETCH;
      end
      S_FETCH: w_state_n = S_LOAD;
      S_LOAD: begin
        if (w_dur == DUR_W'(END_DUR)) begin
          w_end = 1'b1;
        end else begin
          w_hp_n    = w_hp;
          w_rem_n   = w_dur;
          w_div_clr = 1'b1;
          w_tone_n  = (w_hp != HP_W'(REST_HP));
          w_state_n = S_NOTE;
        end
      end
      S_NOTE: begin
        w_div_en = 1'b1;
        if (w_tick) begin
          w_rem_n = r_rem - 1'b1;
          if (r_rem == DUR_W'(1)) begin
            w_tone_n = 1'b0;
            if (GAP_TICKS > 0) begin
              w_gap_n   = '0;
              w_state_n = S_GAP;
            end else begin
              w_adv = 1'b1;
            end
          end
        end
      end
      S_GAP: begin
        w_div_en = 1'b1;
        if (w_tick) begin
          if (r_gap == GAP_W'(GAP_TICKS - 1)) w_adv = 1'b1;
          else                                 w_gap_n = r_gap + 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // The last table slot ends the song rather than wrapping back to entry 0.
    if (w_adv) begin
      if (r_addr == '1) begin
        w_end = 1'b1;
      end else begin
        w_addr_n  = r_addr + 1'b1;
        w_state_n = S_FETCH;
      end
    end

    if (w_end) begin
      w_done_n = 1'b1;
      w_addr_n = '0;
`ifdef SONG_SEQUENCER_LOOP_EN
      w_state_n = S_FETCH;
`else
      w_state_n = S_IDLE;
`endif
    end

    if (i_stop) begin
      w_state_n = S_IDLE;
      w_tone_n  = 1'b0;
      w_addr_n  = '0;
      w_done_n  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= '0;
      r_hp   <= '0;
      r_rem  <= '0;
      r_gap  <= '0;
      r_tone <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_addr <= w_addr_n;
      r_hp   <= w_hp_n;
      r_rem  <= w_rem_n;
      r_gap  <= w_gap_n;
      r_tone <= w_tone_n;
      r_done <= w_done_n;
    end
  end

  assign o_rom_addr    = r_addr;
  assign o_half_period = r_hp;
  assign o_tone_en     = r_tone;
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Controller that plays a song through the square-wave tone generator. Walks a note table in a synchronous ROM, where each entry is a half-period plus a duration. Drives the generator's half-period value and gate for exactly the programmed time, and inserts a short silent gap between notes. Sits between the note ROM and the tone generator, and replaces free-running note indexing with play/stop control, rests and a clean end-of-song.

## Interface
- `ADDR_W`, default 6: note-table address width (64 entries).
- `HP_W`, default 15: half-period field width, in clocks; matches the tone generator counter.
- `DUR_W`, default 8: duration field width, in ticks.
- `TICK_DIV`, default 20910: clocks per duration tick; must be ≥ 2.
- `GAP_TICKS`, default 1: silent ticks after each note; 0 means no gap.
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `play`  in  1: start request; sampled in IDLE only.
- `stop`  in  1: abort request; honoured in any state.
- `rom_addr`  out  ADDR_W: note-table address.
- `rom_data`  in  DUR_W+HP_W: entry `{dur, hp}`, valid one cycle after `rom_addr`.
- `half_period`  out  HP_W: compare value for the tone generator.
- `tone_en`  out  1: gate for the tone generator; the speaker is silent when low.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when the end of the song is reached.

## Operation
- **Entry coding:**
  - `dur==0` marks end of song.
  - `hp==0` is a rest: the entry is timed normally, but `tone_en` stays 0.
- **States:** IDLE, FETCH, LOAD, NOTE, GAP.
- **IDLE:** `rom_addr`=0, `tone_en`=0. If `play`=1 and `stop`=0, go to FETCH.
- **FETCH:** `rom_addr` is held for one cycle, then go to LOAD.
- **LOAD:** sample `rom_data`.
  - If `dur==0`: pulse `done` and go to IDLE (for loop behaviour, see Configuration).
  - Otherwise: latch `half_period`=hp and `remaining`=dur, clear the tick divider, set `tone_en`=(hp!=0), go to NOTE.
- **NOTE:**
  - The divider counts 0..TICK_DIV-1; each wrap decrements `remaining`.
  - When the wrap takes `remaining` from 1 to 0: clear `tone_en`.
  - Then go to GAP if GAP_TICKS>0; otherwise increment `rom_addr` and go to FETCH.
- **GAP:** `tone_en`=0 for GAP_TICKS ticks, then increment `rom_addr` and go to FETCH.
- **Address wrap:** if an entry at address 2^ADDR_W-1 finishes, treat it as end of song. Do not wrap silently.
- **`stop`:** from any state, the next state is IDLE with `tone_en`=0, `rom_addr`=0 and `done` not pulsed. `stop` wins over a simultaneous `play`.
- **`play` while busy:** ignored.
- **Widths:**
  - `remaining` is DUR_W bits.
  - The divider is clog2(TICK_DIV) bits.
  - The gap counter is clog2(GAP_TICKS+1) bits.
  - No arithmetic overflow is possible; all counters reload before wrapping.

## Timing
- **Reset values:** `rom_addr`=0, `half_period`=0, `tone_en`=0, `busy`=0, `done`=0, state IDLE, all counters 0.
- **Start latency:** with `play` sampled at edge N, `rom_addr` is presented in cycle N+1, the entry is sampled at edge N+2, and `tone_en`/`half_period` are valid from cycle N+3.
- **Note length:** `tone_en` stays high for exactly dur×TICK_DIV cycles.
- **Note spacing:** tone-off to next tone-on is GAP_TICKS×TICK_DIV + 2 cycles (FETCH + LOAD).
- **`half_period` stability:** changes only at LOAD, so the tone generator never sees a mid-note change.
- **`done`:** asserted in the cycle after the LOAD that sees `dur==0`; `busy` falls in that same cycle.
- **Reset mid-note:** all outputs return to their reset values asynchronously.

## Configuration
- `SONG_SEQUENCER_LOOP_EN` defined:
  - End of song (`dur==0`, or last address) pulses `done`, sets `rom_addr`=0 and goes to FETCH.
  - Playback repeats until `stop`; `busy` stays 1.
- `SONG_SEQUENCER_LOOP_EN` undefined:
  - End of song pulses `done` and returns to IDLE.
  - Playback only restarts on a new `play`.

## Structure
- **Package `song_seq_pkg`:**
  - State enum.
  - Field-slicing constants for `{dur, hp}`.
  - `END_DUR` = 0 and `REST_HP` = 0 constants.
- **Sub-module `tick_divider`:** `clk`, `rst`, `clr`, `en` → `tick` pulse every TICK_DIV enabled cycles. One instance, shared by NOTE and GAP.

## Test plan
Bench uses TICK_DIV=4, GAP_TICKS=1, and a 1-cycle-latency behavioural ROM.
- **Single note:** ROM[0]={3,100}, ROM[1]={0,x}; `play` pulse → `tone_en` high 12 cycles with `half_period`=100, then `done` pulse and IDLE; `tone_en` rises 3 cycles after `play`.
- **Rest:** ROM[0]={2,0}, ROM[1]={1,50}, ROM[2]={0,x} → `tone_en` low for 8 cycles + 4-cycle gap + 2 cycles, then high 4 cycles at 50.
- **Stop during a note:** `stop` mid-NOTE of ROM[0]={10,200} → next cycle IDLE, `tone_en`=0, `rom_addr`=0, no `done`; a subsequent `play` restarts from entry 0.
- **Simultaneous requests:** `play` and `stop` together in IDLE → remains IDLE; `play` during NOTE → no effect on timing.
- **Loop:** with `SONG_SEQUENCER_LOOP_EN` defined and a 2-note song, one `done` pulse per pass and `busy` continuous over 3 passes. Without the macro: IDLE after the first pass.
- **Async reset:** `rst` asserted mid-GAP → outputs reset immediately without waiting for a clock edge; last-address wrap with ADDR_W=2 and all durations nonzero → `done` after the 4th entry.
